// File: rtl/debounce_pkg.sv
// Shared types and constants for the key debounce stage: FSM state encoding,
// default timing constants and the counter width helper.
package debounce_pkg;

    typedef enum logic [1:0] {
        S_HIGH = 2'd0,
        S_FALL = 2'd1,
        S_LOW  = 2'd2,
        S_RISE = 2'd3
    } state_t;

    localparam int DEF_CNT_MAX  = 500000;
    localparam int DEF_HOLD_MUL = 100;

    // Smallest width (at least 1) whose range 0..2^w-1 covers value-1.
    function automatic int cnt_width(input int value);
        int w;
        w = 1;
        while (w < 31 && (1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/debounce_timer.sv
// Window counter: counts 0..CNT_MAX-1 while enabled, flags the last count and
// wraps to 0 there; clr forces it back to 0.
module debounce_timer
    import debounce_pkg::*;
#(
    parameter int CNT_MAX = DEF_CNT_MAX,
    parameter int CNT_W   = cnt_width(CNT_MAX)
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             clr,
    input  logic             en,
    output logic             done,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge CLK) begin
        if (!RST_n || clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CNT_W'(1);
        end
    end

    assign cnt  = cnt_reg;
    assign done = (cnt_reg == CNT_LAST);

endmodule

// File: rtl/key_debounce.sv
// Key debouncer fed by edge-detector pulses: a level change is accepted only
// after CNT_MAX quiet clocks. Long-press strobe built only with DEBOUNCE_HOLD_EN.
module key_debounce
    import debounce_pkg::*;
#(
    parameter int CNT_MAX  = DEF_CNT_MAX,
    parameter int CNT_W    = cnt_width(CNT_MAX),
    parameter int HOLD_MUL = DEF_HOLD_MUL
) (
    input  logic CLK,
    input  logic RST_n,
    input  logic H2L_Sig,
    input  logic L2H_Sig,
    output logic Pin_Out,
    output logic Press_Pulse,
    output logic Release_Pulse,
    output logic Hold_Pulse
);

    state_t           state_reg;
    state_t           state_next;
    logic             press_reg;
    logic             press_next;
    logic             release_reg;
    logic             release_next;
    logic             tmr_clr;
    logic             tmr_en;
    logic             tmr_done;
    logic [CNT_W-1:0] tmr_cnt;
    logic             h2l;
    logic             l2h;

    // Coincident edges cancel each other out.
    assign h2l = H2L_Sig & ~L2H_Sig;
    assign l2h = L2H_Sig & ~H2L_Sig;

    debounce_timer #(
        .CNT_MAX (CNT_MAX),
        .CNT_W   (CNT_W)
    ) u_window_timer (
        .CLK   (CLK),
        .RST_n (RST_n),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .done  (tmr_done),
        .cnt   (tmr_cnt)
    );

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state_reg   <= S_HIGH;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            press_reg   <= press_next;
            release_reg <= release_next;
        end
    end

    // The timer is held clear unless a check is in progress and no edge or
    // completion occurs this cycle; edges always win over completion.
    always_comb begin
        state_next   = state_reg;
        press_next   = 1'b0;
        release_next = 1'b0;
        tmr_clr      = 1'b1;
        tmr_en       = 1'b0;
        case (state_reg)
            S_HIGH: begin
                if (h2l) state_next = S_FALL;
            end
            S_FALL: begin
                if (l2h) begin
                    state_next = S_HIGH;
                end else if (h2l) begin
                    state_next = S_FALL;
                end else if (tmr_done) begin
                    state_next = S_LOW;
                    press_next = 1'b1;
                end else begin
                    tmr_clr = 1'b0;
                    tmr_en  = 1'b1;
                end
            end
            S_LOW: begin
                if (l2h) state_next = S_RISE;
            end
            S_RISE: begin
                if (h2l) begin
                    state_next = S_LOW;
                end else if (l2h) begin
                    state_next = S_RISE;
                end else if (tmr_done) begin
                    state_next   = S_HIGH;
                    release_next = 1'b1;
                end else begin
                    tmr_clr = 1'b0;
                    tmr_en  = 1'b1;
                end
            end
            default: state_next = S_HIGH;
        endcase
    end

    // The output level stays at its old value throughout a check.
    assign Pin_Out       = (state_reg == S_HIGH) || (state_reg == S_FALL);
    assign Press_Pulse   = press_reg;
    assign Release_Pulse = release_reg;

    wire unused_tmr_cnt = ^tmr_cnt;

`ifdef DEBOUNCE_HOLD_EN
    localparam int                HOLD_W    = cnt_width(HOLD_MUL + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MUL - 1);
    localparam logic [HOLD_W-1:0] HOLD_FULL = HOLD_W'(HOLD_MUL);

    logic [HOLD_W-1:0] hold_cnt_reg;
    logic              hold_reg;
    logic              win_clr;
    logic              win_en;
    logic              win_done;
    logic [CNT_W-1:0]  win_cnt;

    // Counting pauses during a rise check so an aborted release resumes it;
    // a full hold count freezes everything until the key is released.
    assign win_clr = (state_reg == S_HIGH) || (state_reg == S_FALL);
    assign win_en  = (state_reg == S_LOW) && (hold_cnt_reg != HOLD_FULL);

    debounce_timer #(
        .CNT_MAX (CNT_MAX),
        .CNT_W   (CNT_W)
    ) u_hold_timer (
        .CLK   (CLK),
        .RST_n (RST_n),
        .clr   (win_clr),
        .en    (win_en),
        .done  (win_done),
        .cnt   (win_cnt)
    );

    always_ff @(posedge CLK) begin
        if (!RST_n || win_clr) begin
            hold_cnt_reg <= '0;
            hold_reg     <= 1'b0;
        end else begin
            hold_reg <= 1'b0;
            if (win_en && win_done) begin
                hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
                hold_reg     <= (hold_cnt_reg == HOLD_LAST);
            end
        end
    end

    assign Hold_Pulse = hold_reg;

    wire unused_win_cnt = ^win_cnt;
`else
    assign Hold_Pulse = 1'b0;

    wire unused_hold_mul = (HOLD_MUL > 0);
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with CNT_MAX=8, HOLD_MUL=3: expected outputs
// are queued as each step is driven and compared after the clock edge.
module tb_key_debounce;

    localparam int CNT_MAX  = 8;
    localparam int CNT_W    = 3;
    localparam int HOLD_MUL = 3;

    typedef struct packed {
        logic pin;
        logic press;
        logic rel;
        logic hold;
    } obs_t;

    localparam obs_t HI    = 4'b1000;
    localparam obs_t LO    = 4'b0000;
    localparam obs_t PRESS = 4'b0100;
    localparam obs_t REL   = 4'b1010;
`ifdef DEBOUNCE_HOLD_EN
    localparam obs_t HOLD_EXP = 4'b0001;
`else
    localparam obs_t HOLD_EXP = 4'b0000;
`endif

    logic CLK     = 1'b0;
    logic RST_n   = 1'b0;
    logic H2L_Sig = 1'b0;
    logic L2H_Sig = 1'b0;
    logic Pin_Out;
    logic Press_Pulse;
    logic Release_Pulse;
    logic Hold_Pulse;

    obs_t exp_q[$];
    int   check_cnt = 0;
    int   pass_cnt  = 0;
    int   step_no   = 0;

    key_debounce #(
        .CNT_MAX  (CNT_MAX),
        .CNT_W    (CNT_W),
        .HOLD_MUL (HOLD_MUL)
    ) dut (
        .CLK           (CLK),
        .RST_n         (RST_n),
        .H2L_Sig       (H2L_Sig),
        .L2H_Sig       (L2H_Sig),
        .Pin_Out       (Pin_Out),
        .Press_Pulse   (Press_Pulse),
        .Release_Pulse (Release_Pulse),
        .Hold_Pulse    (Hold_Pulse)
    );

    always #5 CLK = ~CLK;

    // One clock: drive inputs, queue the expected outputs after the edge,
    // then sample 1 time unit past the edge and compare.
    task automatic step(input logic h, input logic l, input obs_t e, input string tag);
        obs_t got;
        obs_t want;
        H2L_Sig = h;
        L2H_Sig = l;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        H2L_Sig = 1'b0;
        L2H_Sig = 1'b0;
        want = exp_q.pop_front();
        got  = {Pin_Out, Press_Pulse, Release_Pulse, Hold_Pulse};
        check_cnt++;
        assert (got === want) pass_cnt++;
        else $error("FAIL %s step %0d: pin/press/rel/hold observed %b required %b",
                    tag, step_no, got, want);
        $display("step %0d %s rst_n=%b h2l=%b l2h=%b out=%b", step_no, tag, RST_n, h, l, got);
        step_no++;
    endtask

    task automatic idle(input int n, input obs_t e, input string tag);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, e, tag);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held 3 cycles; an edge during reset must be ignored.
        RST_n = 1'b0;
        step(1'b0, 1'b0, HI, "reset");
        step(1'b1, 1'b0, HI, "reset_h2l");
        step(1'b0, 1'b0, HI, "reset");
        RST_n = 1'b1;
        idle(10, HI, "post_reset");

        // Clean press and release, 8 clocks each.
        step(1'b1, 1'b0, HI, "fall_start");
        idle(7, HI, "fall_wait");
        step(1'b0, 1'b0, PRESS, "press");
        idle(2, LO, "low");
        step(1'b1, 1'b0, LO, "h2l_in_low");
        idle(9, LO, "low_quiet");
        step(1'b0, 1'b1, LO, "rise_start");
        idle(7, LO, "rise_wait");
        step(1'b0, 1'b0, REL, "release");
        idle(2, HI, "high");
        step(1'b0, 1'b1, HI, "l2h_in_high");
        idle(9, HI, "high_quiet");

        // Bounce: L2H three clocks after H2L aborts.
        step(1'b1, 1'b0, HI, "bounce_h2l");
        idle(2, HI, "bounce_wait");
        step(1'b0, 1'b1, HI, "bounce_abort");
        idle(10, HI, "bounce_quiet");

        // Restart at cycle 5 moves the fall to cycle 13.
        step(1'b1, 1'b0, HI, "restart_h2l0");
        idle(4, HI, "restart_wait");
        step(1'b1, 1'b0, HI, "restart_h2l5");
        idle(7, HI, "restart_wait");
        step(1'b0, 1'b0, PRESS, "restart_press");
        idle(2, LO, "low");
        step(1'b0, 1'b1, LO, "rise_start");
        idle(7, LO, "rise_wait");
        step(1'b0, 1'b0, REL, "release");
        idle(2, HI, "high");

        // L2H in the completion cycle wins: no press.
        step(1'b1, 1'b0, HI, "late_abort_h2l");
        idle(7, HI, "late_abort_wait");
        step(1'b0, 1'b1, HI, "abort_at_done");
        idle(10, HI, "abort_quiet");

        // Coincident edges are no edge.
        step(1'b1, 1'b1, HI, "both_edges");
        idle(10, HI, "both_quiet");

        // Reset at cnt=4 in a fall check.
        step(1'b1, 1'b0, HI, "rst_mid_h2l");
        idle(4, HI, "rst_mid_wait");
        RST_n = 1'b0;
        step(1'b0, 1'b0, HI, "reset_mid_fall");
        RST_n = 1'b1;
        idle(10, HI, "after_reset");

        // Reset from the stable low state.
        step(1'b1, 1'b0, HI, "fall_start");
        idle(7, HI, "fall_wait");
        step(1'b0, 1'b0, PRESS, "press");
        idle(2, LO, "low");
        RST_n = 1'b0;
        step(1'b0, 1'b0, HI, "reset_from_low");
        RST_n = 1'b1;
        idle(10, HI, "after_reset");

        // Long hold: hold strobe at 8+24 clocks, once only.
        step(1'b1, 1'b0, HI, "hold_h2l");
        idle(7, HI, "fall_wait");
        step(1'b0, 1'b0, PRESS, "hold_press");
        idle(23, LO, "hold_wait");
        step(1'b0, 1'b0, HOLD_EXP, "hold");
        idle(30, LO, "hold_once");

        // Rise aborted by H2L, mid-window and at completion.
        step(1'b0, 1'b1, LO, "rise_start");
        idle(2, LO, "rise_wait");
        step(1'b1, 1'b0, LO, "rise_abort");
        idle(10, LO, "rise_abort_quiet");
        step(1'b0, 1'b1, LO, "rise_start");
        idle(7, LO, "rise_wait");
        step(1'b1, 1'b0, LO, "rise_abort_at_done");
        idle(3, LO, "rise_abort_quiet");

        // Rise restart by a second L2H.
        step(1'b0, 1'b1, LO, "rise_l2h0");
        idle(3, LO, "rise_wait");
        step(1'b0, 1'b1, LO, "rise_restart");
        idle(7, LO, "rise_wait");
        step(1'b0, 1'b0, REL, "release_after_restart");
        idle(3, HI, "high");

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
